// File: rtl/contador_cm_medidor_if.sv
// Purpose: measurement request / echo / result bundle for contador_cm_medidor.
// Signals:
//   medir     - request to start one measurement (master -> slave)
//   pulso     - echo pulse, already synchronous to the clock (master -> slave)
//   distancia - last result in BCD, digit 0 in bits [3:0] (slave -> master)
//   pronto    - one-cycle end-of-measurement strobe (slave -> master)
//   ocupado   - measurement in progress (slave -> master)
//   overflow  - last result saturated (slave -> master)
//   timeout   - last request saw no echo (slave -> master)
//   db_estado - current FSM state code (slave -> master)
interface contador_cm_medidor_if #(
  parameter int unsigned D = 3
);
  logic           medir;
  logic           pulso;
  logic [4*D-1:0] distancia;
  logic           pronto;
  logic           ocupado;
  logic           overflow;
  logic           timeout;
  logic [2:0]     db_estado;

  modport master (
    output medir, pulso,
    input  distancia, pronto, ocupado, overflow, timeout, db_estado
  );

  modport slave (
    input  medir, pulso,
    output distancia, pronto, ocupado, overflow, timeout, db_estado
  );
endinterface

// File: rtl/contador_cm_medidor.sv
// Purpose: echo-pulse distance meter. Counts clock cycles while the echo
//   pulse is high, converts every R cycles into one centimetre directly in a
//   BCD counter (with optional round-to-nearest), saturates at 10^D-1 and
//   reports a timeout when no echo starts within ESPERA_MAX cycles.
// Ports:
//   clock  - system clock, all state changes on its rising edge
//   reset  - synchronous, active-high reset
//   io_bus - slave side of contador_cm_medidor_if (medir, pulso in;
//            distancia, pronto, ocupado, overflow, timeout, db_estado out)
module contador_cm_medidor #(
  parameter int unsigned R          = 10,
  parameter int unsigned N          = 4,
  parameter int unsigned D          = 3,
  parameter int unsigned ARREDONDA  = 1,
  parameter int unsigned ESPERA_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  contador_cm_medidor_if.slave    io_bus
);

  // Tick value at which a centimetre is credited: mid-period rounds to nearest.
  localparam int unsigned K_TICK = (ARREDONDA != 0) ? (R / 2) : (R - 1);
  localparam int unsigned WW     = $clog2(ESPERA_MAX);
  localparam int unsigned BW     = 4 * D;

  typedef enum logic [2:0] {
    INICIAL  = 3'b000,
    ESPERA   = 3'b001,
    CONTA    = 3'b010,
    ARMAZENA = 3'b011,
    FINAL    = 3'b100,
    ESGOTADO = 3'b101
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;

  logic [N-1:0]    r_tick;
  logic [BW-1:0]   r_bcd;
  logic            r_sat;
  logic [WW-1:0]   r_espera;

  logic [BW-1:0]   r_distancia;
  logic            r_pronto;
  logic            r_ocupado;
  logic            r_overflow;
  logic            r_timeout;

  logic            w_limpa;
  logic            w_tick_inc;
  logic            w_espera_inc;
  logic            w_carrega;

  logic [BW-1:0]   w_bcd_inc;
  logic            w_todos9;
  logic            w_vai;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    w_prox       = r_estado;
    w_limpa      = 1'b0;
    w_tick_inc   = 1'b0;
    w_espera_inc = 1'b0;
    w_carrega    = 1'b0;
    case (r_estado)
      INICIAL: begin
        if (io_bus.medir) begin
          w_prox  = ESPERA;
          w_limpa = 1'b1;
        end
      end
      ESPERA: begin
        if (io_bus.pulso) begin
          w_prox = CONTA;
        end else if (r_espera == WW'(ESPERA_MAX - 1)) begin
          w_prox = ESGOTADO;
        end else begin
          w_espera_inc = 1'b1;
        end
      end
      CONTA: begin
        if (io_bus.pulso) begin
          w_tick_inc = 1'b1;
        end else begin
          w_prox = ARMAZENA;
        end
      end
      ARMAZENA: begin
        w_carrega = 1'b1;
        w_prox    = FINAL;
      end
      FINAL:    w_prox = INICIAL;
      ESGOTADO: w_prox = INICIAL;
      default:  w_prox = INICIAL;
    endcase
  end

  // BCD +1 with per-digit 9->0 carry; w_todos9 flags the saturation case.
  always_comb begin
    w_bcd_inc = r_bcd;
    w_todos9  = 1'b1;
    w_vai     = 1'b1;
    for (int i = 0; i < int'(D); i++) begin
      if (r_bcd[4*i +: 4] != 4'd9) begin
        w_todos9 = 1'b0;
      end
      if (w_vai) begin
        if (r_bcd[4*i +: 4] == 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_vai               = 1'b0;
        end
      end
    end
  end

  // Tick, BCD and wait counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick   <= '0;
      r_bcd    <= '0;
      r_sat    <= 1'b0;
      r_espera <= '0;
    end else if (w_limpa) begin
      r_tick   <= '0;
      r_bcd    <= '0;
      r_sat    <= 1'b0;
      r_espera <= '0;
    end else begin
      if (w_tick_inc) begin
        r_tick <= (r_tick == N'(R - 1)) ? '0 : r_tick + N'(1);
        // The centimetre is credited on the step that leaves K_TICK.
        if (r_tick == N'(K_TICK)) begin
          if (w_todos9) begin
            r_sat <= 1'b1;
          end else begin
            r_bcd <= w_bcd_inc;
          end
        end
      end
      if (w_espera_inc) begin
        r_espera <= r_espera + WW'(1);
      end
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_distancia <= '0;
      r_pronto    <= 1'b0;
      r_ocupado   <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_pronto  <= (w_prox == FINAL) || (w_prox == ESGOTADO);
      r_ocupado <= (w_prox != INICIAL);
      if (w_limpa) begin
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_carrega) begin
        r_distancia <= r_bcd;
        r_overflow  <= r_sat;
      end
      if (w_prox == ESGOTADO) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign io_bus.distancia = r_distancia;
  assign io_bus.pronto    = r_pronto;
  assign io_bus.ocupado   = r_ocupado;
  assign io_bus.overflow  = r_overflow;
  assign io_bus.timeout   = r_timeout;
  assign io_bus.db_estado = r_estado;

endmodule
